// File: rtl/face_report_pkg.sv
// face_report_pkg
//   Shared constants and state encodings for the detection-report framer.
//   SOF_BYTE  : start-of-frame marker, first byte of every report
//   HDR_BYTES : header length (SOF, N low, N high, flags)
//   tx_state_t: byte-handshake FSM states
//   seg_t     : which part of the frame the byte cursor is in
package face_report_pkg;

   localparam logic [7:0]  SOF_BYTE  = 8'hA5;
   localparam int unsigned HDR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } tx_state_t;

   typedef enum logic [1:0] {
      HDR,
      REC,
      CSUM
   } seg_t;

endpackage

// File: rtl/record_fifo.sv
// record_fifo
//   Circular record buffer with head/tail pointers wrapping at DEPTH.
//   A push is accepted while not full, or when a pop happens in the same
//   cycle. Storage is never cleared; only pointers and count reset.
//   Ports:
//     clock, reset_n : clock, async active-low reset
//     push, wdata    : write request and record
//     pop            : remove head record (ignored when empty)
//     rdata          : head record, combinational read
//     count          : records stored
//     full, empty    : occupancy flags
module record_fifo #(
   parameter int unsigned DEPTH = 100,
   parameter int unsigned WIDTH = 128
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [15:0]      count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [15:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == 16'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem_q[head_q];
   assign count   = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_ok) begin
         tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      end
      if (pop_ok) begin
         head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 16'd1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[tail_q] <= wdata;
      end
   end

endmodule

// File: rtl/face_report_tx.sv
// face_report_tx
//   Buffers detection records and, on each frame_done, sends one report:
//   A5, N[7:0], N[15:8], flags, N records (fields 0.., little-endian),
//   XOR checksum. Bytes go out over a start/done handshake gated by cts.
//   Ports:
//     clock, reset_n        : clock, async active-low reset
//     push, push_rec        : record write pulse and data (field 0 in LSBs)
//     frame_done            : end-of-image pulse, starts or queues a report
//     cts                   : receiver ready, sampled only in LOAD
//     tx_data, tx_start     : byte and level request to the transmitter
//     tx_done               : byte-sent pulse
//     busy                  : report in progress or pending
//     count                 : records stored
//     overflow, drop_count  : sticky drop flag, saturating drop total
module face_report_tx
   import face_report_pkg::*;
#(
   parameter int unsigned DEPTH      = 100,
   parameter int unsigned NUM_FIELDS = 4,
   parameter int unsigned FIELD_W    = 32
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic [NUM_FIELDS*FIELD_W-1:0] push_rec,
   input  logic                          frame_done,
   input  logic                          cts,
   output logic [7:0]                    tx_data,
   output logic                          tx_start,
   input  logic                          tx_done,
   output logic                          busy,
   output logic [15:0]                   count,
   output logic                          overflow,
   output logic [15:0]                   drop_count
);

   localparam int unsigned   RW        = NUM_FIELDS * FIELD_W;
   localparam int unsigned   REC_BYTES = RW / 8;
   localparam int unsigned   BW        = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
   localparam logic [BW-1:0] BYTE_LAST = BW'(REC_BYTES - 1);
   localparam logic [1:0]    HDR_LAST  = 2'(HDR_BYTES - 1);

   tx_state_t   state_q, state_d;
   seg_t        seg_q, seg_d;
   logic [1:0]  hdr_idx_q, hdr_idx_d;
   logic [BW-1:0] byte_idx_q, byte_idx_d;
   logic [15:0] rec_left_q, rec_left_d;
   logic [15:0] n_q, n_d;
   logic [7:0]  csum_q, csum_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        loaded_q, loaded_d;
   logic        pend_q, pend_d;
   logic        ovf_q, ovf_d;
   logic [15:0] drop_q, drop_d;

   logic          fifo_pop, fifo_full, fifo_empty;
   logic [RW-1:0] fifo_rdata;
   logic [7:0]    cur_byte;
   logic          flag_load;
   logic          drop;

   record_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (fifo_pop),
      .wdata   (push_rec),
      .rdata   (fifo_rdata),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Byte at the current cursor. Record bytes are the head record sent
   // LSB-first, which is fields 0.. in order, each little-endian.
   always_comb begin
      cur_byte = '0;
      unique case (seg_q)
         HDR: begin
            unique case (hdr_idx_q)
               2'd0:    cur_byte = SOF_BYTE;
               2'd1:    cur_byte = n_q[7:0];
               2'd2:    cur_byte = n_q[15:8];
               default: cur_byte = {7'b0, ovf_q};
            endcase
         end
         REC:     cur_byte = fifo_rdata[{byte_idx_q, 3'b000} +: 8];
         CSUM:    cur_byte = csum_q;
         default: cur_byte = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      seg_d      = seg_q;
      hdr_idx_d  = hdr_idx_q;
      byte_idx_d = byte_idx_q;
      rec_left_d = rec_left_q;
      n_d        = n_q;
      csum_d     = csum_q;
      tx_data_d  = tx_data_q;
      loaded_d   = loaded_q;
      pend_d     = pend_q;
      fifo_pop   = 1'b0;
      flag_load  = 1'b0;

      if (frame_done && (state_q != IDLE)) begin
         pend_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (frame_done || pend_q) begin
               state_d    = LOAD;
               seg_d      = HDR;
               hdr_idx_d  = '0;
               byte_idx_d = '0;
               n_d        = count;
               csum_d     = '0;
               loaded_d   = 1'b0;
               pend_d     = 1'b0;
            end
         end
         LOAD: begin
            // Load only once per byte so a cts stall cannot re-sample the
            // flags byte or clear overflow a second time.
            if (!loaded_q) begin
               tx_data_d = cur_byte;
               loaded_d  = 1'b1;
               flag_load = (seg_q == HDR) && (hdr_idx_q == HDR_LAST);
            end
            if (cts) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (tx_done) begin
               csum_d   = csum_q ^ tx_data_q;
               loaded_d = 1'b0;
               state_d  = LOAD;
               unique case (seg_q)
                  HDR: begin
                     if (hdr_idx_q == HDR_LAST) begin
                        byte_idx_d = '0;
                        rec_left_d = n_q;
                        seg_d      = (n_q == '0) ? CSUM : REC;
                     end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                     end
                  end
                  REC: begin
                     if (byte_idx_q == BYTE_LAST) begin
                        fifo_pop   = !fifo_empty;
                        byte_idx_d = '0;
                        rec_left_d = rec_left_q - 16'd1;
                        if (rec_left_q == 16'd1) begin
                           seg_d = CSUM;
                        end
                     end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                     end
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A push is dropped only when full with no simultaneous pop.
   always_comb begin
      drop   = push && fifo_full && !fifo_pop;
      ovf_d  = (flag_load ? 1'b0 : ovf_q) | drop;
      drop_d = drop_q;
      if (drop && (drop_q != '1)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         seg_q      <= HDR;
         hdr_idx_q  <= '0;
         byte_idx_q <= '0;
         rec_left_q <= '0;
         n_q        <= '0;
         csum_q     <= '0;
         tx_data_q  <= '0;
         loaded_q   <= 1'b0;
         pend_q     <= 1'b0;
         ovf_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         seg_q      <= seg_d;
         hdr_idx_q  <= hdr_idx_d;
         byte_idx_q <= byte_idx_d;
         rec_left_q <= rec_left_d;
         n_q        <= n_d;
         csum_q     <= csum_d;
         tx_data_q  <= tx_data_d;
         loaded_q   <= loaded_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_start   = (state_q == SEND);
   assign busy       = (state_q != IDLE) || pend_q;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_face_report_tx.sv
module tb_face_report_tx;

   localparam int DEPTH = 4;
   localparam int NF    = 4;
   localparam int FW    = 32;
   localparam int RW    = NF * FW;
   localparam int RB    = RW / 8;

   logic          clock      = 1'b0;
   logic          reset_n    = 1'b0;
   logic          push       = 1'b0;
   logic [RW-1:0] push_rec   = '0;
   logic          frame_done = 1'b0;
   logic          cts        = 1'b1;
   logic          tx_done    = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          busy;
   logic [15:0]   count;
   logic          overflow;
   logic [15:0]   drop_count;

   face_report_tx #(
      .DEPTH      (DEPTH),
      .NUM_FIELDS (NF),
      .FIELD_W    (FW)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push),
      .push_rec   (push_rec),
      .frame_done (frame_done),
      .cts        (cts),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_done    (tx_done),
      .busy       (busy),
      .count      (count),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]    exp_q[$];
   logic [RW-1:0] model_q[$];
   int nstart = 0;
   int ndone  = 0;
   int start_at[1024];
   int done_at[1024];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, started %0d done %0d pending %0d", name, nstart, ndone, exp_q.size());
   endtask

   function automatic logic [RW-1:0] mkrec(input logic [31:0] f0, input logic [31:0] f1,
                                           input logic [31:0] f2, input logic [31:0] f3);
      return {f3, f2, f1, f0};
   endfunction

   // Transmitter model and scoreboard monitor: each byte is compared when
   // tx_start first appears, then completed with a tx_done pulse.
   initial begin : monitor
      logic       in_flight;
      int         delay;
      logic [7:0] held;
      logic [7:0] e;
      in_flight = 1'b0;
      delay     = 0;
      held      = '0;
      forever begin
         @(negedge clock);
         tx_done = 1'b0;
         if (!reset_n) begin
            in_flight = 1'b0;
         end else if (tx_start && !in_flight) begin
            in_flight        = 1'b1;
            delay            = 2;
            held             = tx_data;
            start_at[nstart] = cyc;
            nstart++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got 0x%0h expected none", tx_data);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", 32'(tx_data), 32'(e));
            end
         end else if (in_flight) begin
            if (delay == 0) begin
               check("tx_data_stable", 32'(tx_data), 32'(held));
               tx_done        = 1'b1;
               in_flight      = 1'b0;
               done_at[ndone] = cyc;
               ndone++;
            end else begin
               delay--;
            end
         end
      end
   end

   task automatic sync();
      @(negedge clock);
      #1;
   endtask

   task automatic do_push(input logic [RW-1:0] r);
      sync();
      push     = 1'b1;
      push_rec = r;
      if (model_q.size() < DEPTH) model_q.push_back(r);
      sync();
      push = 1'b0;
   endtask

   // Returns the cycle during which frame_done is high.
   task automatic pulse_fd(output int fd_cyc);
      sync();
      frame_done = 1'b1;
      fd_cyc     = cyc;
      sync();
      frame_done = 1'b0;
   endtask

   // Expected report built from the bench's own record model.
   task automatic exp_frame(input int n, input logic [7:0] flags);
      logic [7:0]    b[$];
      logic [7:0]    x;
      logic [RW-1:0] r;
      logic [15:0]   n16;
      n16 = 16'(n);
      b.push_back(8'hA5);
      b.push_back(n16[7:0]);
      b.push_back(n16[15:8]);
      b.push_back(flags);
      for (int i = 0; i < n; i++) begin
         r = model_q.pop_front();
         for (int k = 0; k < RB; k++) b.push_back(r[8*k +: 8]);
      end
      x = '0;
      foreach (b[i]) x = x ^ b[i];
      b.push_back(x);
      foreach (b[i]) exp_q.push_back(b[i]);
   endtask

   task automatic wait_start(input int target, input string name);
      int t;
      t = 0;
      while (nstart < target && t < 2000) begin
         sync();
         t++;
      end
      if (nstart < target) fail_timeout(name);
   endtask

   task automatic wait_done(input int target, input string name);
      int t;
      t = 0;
      while (ndone < target && t < 2000) begin
         sync();
         t++;
      end
      if (ndone < target) fail_timeout(name);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 4000) begin
         sync();
         t++;
      end
      if (busy || exp_q.size() != 0) begin
         fail_timeout(name);
         exp_q.delete();
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int fd;
      int base;
      int bs;

      // Reset values
      repeat (3) sync();
      check("rst_tx_data",    32'(tx_data),    32'h0);
      check("rst_tx_start",   32'(tx_start),   32'h0);
      check("rst_busy",       32'(busy),       32'h0);
      check("rst_count",      32'(count),      32'h0);
      check("rst_overflow",   32'(overflow),   32'h0);
      check("rst_drop_count", 32'(drop_count), 32'h0);
      reset_n = 1'b1;
      repeat (2) sync();

      // Empty frame: A5 00 00 00 A5
      base = ndone;
      bs   = nstart;
      exp_frame(0, 8'h00);
      pulse_fd(fd);
      wait_done(base + 5, "empty_frame");
      check("busy_before_last_done", 32'(busy), 32'h1);
      @(posedge clock);
      #1;
      check("busy_after_last_done", 32'(busy), 32'h0);
      check("fd_to_send_cycles", 32'(start_at[bs] - fd), 32'd2);
      wait_idle("empty_frame_idle");

      // Two records, 37 bytes
      do_push(mkrec(32'd1, 32'h10, 32'h20, 32'h12345678));
      do_push(mkrec(32'd2, 32'h30, 32'h40, 32'hFFFFFFFF));
      check("count_two", 32'(count), 32'd2);
      bs = nstart;
      exp_frame(2, 8'h00);
      pulse_fd(fd);
      wait_idle("two_records");
      check("two_records_len", 32'(nstart - bs), 32'd37);
      check("interbyte_cycles", 32'(start_at[bs+1] - done_at[bs]), 32'd2);
      check("count_after_two", 32'(count), 32'd0);

      // Overflow at DEPTH=4: 6 pushes, 2 dropped
      for (int i = 1; i <= 6; i++) begin
         do_push(mkrec(32'(i), 32'(i * 16), 32'(i * 256), 32'hC0DE0000 + 32'(i)));
      end
      check("ovf_count",      32'(count),      32'd4);
      check("ovf_drop_count", 32'(drop_count), 32'd2);
      check("ovf_flag",       32'(overflow),   32'h1);
      base = ndone;
      exp_frame(4, 8'h01);
      pulse_fd(fd);
      wait_done(base + 4, "ovf_header");
      @(posedge clock);
      #1;
      check("ovf_cleared_after_hdr", 32'(overflow), 32'h0);
      wait_idle("ovf_frame");
      check("ovf_count_after",      32'(count),      32'd0);
      check("ovf_drop_count_after", 32'(drop_count), 32'd2);

      // Push during drain, merged pending frame_done pulses
      do_push(mkrec(32'hA, 32'hAA, 32'hAAA, 32'hAAAA));
      do_push(mkrec(32'hB, 32'hBB, 32'hBBB, 32'hBBBB));
      base = ndone;
      bs   = nstart;
      exp_frame(2, 8'h00);
      pulse_fd(fd);
      wait_done(base + 10, "drain_mid");
      do_push(mkrec(32'hC, 32'hCC, 32'hCCC, 32'hCCCC));
      check("busy_mid_drain", 32'(busy), 32'h1);
      pulse_fd(fd);
      pulse_fd(fd);
      exp_frame(1, 8'h00);
      wait_idle("pending_frame");
      check("pending_restart_cycles", 32'(start_at[bs+37] - done_at[bs+36]), 32'd3);
      check("pending_total_bytes", 32'(nstart - bs), 32'd58);

      // CTS stall after the second byte
      do_push(mkrec(32'hD, 32'hDD, 32'hDDD, 32'hDDDD));
      base = ndone;
      bs   = nstart;
      exp_frame(1, 8'h00);
      pulse_fd(fd);
      wait_start(bs + 2, "cts_byte2_start");
      cts = 1'b0;
      wait_done(base + 2, "cts_byte2_done");
      repeat (4) sync();
      check("cts_hold_start", 32'(tx_start), 32'h0);
      check("cts_hold_data",  32'(tx_data),  32'h00);
      check("cts_hold_busy",  32'(busy),     32'h1);
      cts = 1'b1;
      @(posedge clock);
      #1;
      check("cts_resume_start", 32'(tx_start), 32'h1);
      check("cts_resume_data",  32'(tx_data),  32'h00);
      wait_idle("cts_frame");

      // Reset during a record byte
      do_push(mkrec(32'hE, 32'hEE, 32'hEEE, 32'hEEEE));
      do_push(mkrec(32'hF, 32'hFF, 32'hFFF, 32'hFFFF));
      exp_frame(2, 8'h00);
      bs = nstart;
      pulse_fd(fd);
      wait_start(bs + 8, "rst_mid_frame");
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_tx_start", 32'(tx_start), 32'h0);
      check("rst_mid_count",    32'(count),    32'h0);
      check("rst_mid_busy",     32'(busy),     32'h0);
      exp_q.delete();
      model_q.delete();
      repeat (2) sync();
      reset_n = 1'b1;
      check("rst_mid_drop_count", 32'(drop_count), 32'h0);
      sync();
      exp_frame(0, 8'h00);
      pulse_fd(fd);
      wait_idle("post_reset_frame");
      repeat (3) sync();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
